// File: rtl/rv_uart_dbg_pkg.sv
// Shared opcodes, reply codes, parser states and the reply bundle for the UART debug bridge.
// Optional trailing-checksum state exists only when UART_DBG_CHECKSUM_EN is defined.
package rv_uart_dbg_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_PING  = 8'h50;
    localparam logic [7:0] RSP_ACK  = 8'h06;
    localparam logic [7:0] RSP_NAK  = 8'h15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_GET_ADDR,
        ST_GET_DATA,
`ifdef UART_DBG_CHECKSUM_EN
        ST_GET_CSUM,
`endif
        ST_BUS,
        ST_SEND
    } state_t;

    // Up to four reply bytes, sent LSB first, plus how many of them are valid.
    typedef struct packed {
        logic [31:0] bytes;
        logic [2:0]  cnt;
    } reply_t;

    function automatic int ADDR_BYTES(input int addr_w);
        return addr_w / 8;
    endfunction

endpackage

// File: rtl/rv_uart_dbg_txseq.sv
// Reply sequencer: shifts out up to 4 loaded bytes as tx_start pulses, LSB first; done pulses with the last tx_start.
// Latency: first tx_start one cycle after load when the UART is idle.
// Backpressure: waits for !tx_busy before each byte and ignores tx_busy for 2 cycles after each pulse.
module rv_uart_dbg_txseq
    import rv_uart_dbg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  reply_t     reply,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       done
);

    // Covers the pulse cycle plus the two cycles before the UART raises busy.
    localparam logic [1:0] HOLD = 2'd3;

    logic [31:0] shreg;
    logic [2:0]  remain;
    logic [1:0]  hold;
    logic        fire;

    assign fire = (remain != 3'd0) && (hold == 2'd0) && !tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            remain   <= '0;
            hold     <= '0;
            tx_data  <= '0;
            tx_start <= 1'b0;
            done     <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            done     <= 1'b0;
            if (hold != 2'd0)
                hold <= hold - 2'd1;
            if (load) begin
                shreg  <= reply.bytes;
                remain <= reply.cnt;
            end else if (fire) begin
                tx_data  <= shreg[7:0];
                tx_start <= 1'b1;
                shreg    <= shreg >> 8;
                remain   <= remain - 3'd1;
                hold     <= HOLD;
                done     <= (remain == 3'd1);
            end
        end
    end

endmodule

// File: rtl/rv_uart_dbg_bridge.sv
// Serial debug bridge: parses host frames (WRITE/READ/PING) from rv_uart bytes into word bus accesses and replies; UART_DBG_CHECKSUM_EN adds a trailing XOR byte.
// Latency: reply begins one cycle after the last frame byte (PING/NAK) or after the mem_ready cycle (READ/WRITE).
// Backpressure: bytes stay in the UART outside parsing states; bus requests held until mem_ready; replies paced by tx_busy.
module rv_uart_dbg_bridge
    import rv_uart_dbg_pkg::*;
#(
    parameter int          ADDR_W  = 16,
    parameter logic [23:0] TIMEOUT = 24'd1000000,
    parameter logic [7:0]  VERSION = 8'h01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_clr,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready,
    output logic              err
);

    localparam int         AB      = ADDR_BYTES(ADDR_W);
    localparam logic [1:0] AB_LAST = 2'(AB - 1);
`ifdef UART_DBG_CHECKSUM_EN
    localparam state_t FRAME_END = ST_GET_CSUM;
`else
    localparam state_t FRAME_END = ST_BUS;
`endif

    state_t      state, state_nxt;
    logic [7:0]  opcode;
    logic [1:0]  byte_cnt;
    logic [23:0] tmo_cnt;
    logic        in_get, accept, tmo_hit, err_set, load, bus_go, tx_done;
    reply_t      reply;
`ifdef UART_DBG_CHECKSUM_EN
    logic [7:0]  csum_r;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        load        = 1'b0;
        err_set     = 1'b0;
        reply.bytes = '0;
        reply.cnt   = 3'd1;
        in_get      = (state == ST_GET_ADDR) || (state == ST_GET_DATA)
`ifdef UART_DBG_CHECKSUM_EN
                      || (state == ST_GET_CSUM)
`endif
                      ;
        accept  = (in_get || state == ST_IDLE) && rx_valid && !rx_clr;
        tmo_hit = in_get && !accept && (TIMEOUT != 24'd0) && (tmo_cnt == TIMEOUT);
        case (state)
            ST_IDLE: if (accept) begin
                case (rx_data)
                    OP_WRITE, OP_READ: state_nxt = ST_GET_ADDR;
`ifdef UART_DBG_CHECKSUM_EN
                    OP_PING: state_nxt = ST_GET_CSUM;
`else
                    OP_PING: begin
                        state_nxt   = ST_SEND;
                        load        = 1'b1;
                        reply.bytes = {24'h0, VERSION};
                    end
`endif
                    default: begin
                        state_nxt   = ST_SEND;
                        load        = 1'b1;
                        reply.bytes = {24'h0, RSP_NAK};
                        err_set     = 1'b1;
                    end
                endcase
            end
            ST_GET_ADDR: if (accept && byte_cnt == AB_LAST)
                state_nxt = (opcode == OP_WRITE) ? ST_GET_DATA : FRAME_END;
            ST_GET_DATA: if (accept && byte_cnt == 2'd3)
                state_nxt = FRAME_END;
`ifdef UART_DBG_CHECKSUM_EN
            ST_GET_CSUM: if (accept) begin
                if (rx_data != csum_r) begin
                    state_nxt   = ST_SEND;
                    load        = 1'b1;
                    reply.bytes = {24'h0, RSP_NAK};
                    err_set     = 1'b1;
                end else if (opcode == OP_PING) begin
                    state_nxt   = ST_SEND;
                    load        = 1'b1;
                    reply.bytes = {24'h0, VERSION};
                end else begin
                    state_nxt = ST_BUS;
                end
            end
`endif
            ST_BUS: if (mem_ready) begin
                state_nxt   = ST_SEND;
                load        = 1'b1;
                reply.bytes = mem_we ? {24'h0, RSP_ACK} : mem_rdata;
                reply.cnt   = mem_we ? 3'd1 : 3'd4;
            end
            ST_SEND: if (tx_done) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        if (tmo_hit) begin
            state_nxt = ST_IDLE;
            err_set   = 1'b1;
        end
        bus_go = (state_nxt == ST_BUS) && (state != ST_BUS);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_clr    <= 1'b0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_re    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            opcode    <= '0;
            byte_cnt  <= '0;
            tmo_cnt   <= '0;
`ifdef UART_DBG_CHECKSUM_EN
            csum_r    <= '0;
`endif
        end else begin
            rx_clr <= accept;
            err    <= err_set;
            if (state_nxt != state) byte_cnt <= '0;
            else if (accept)        byte_cnt <= byte_cnt + 2'd1;
            if (!in_get || accept || state_nxt != state) tmo_cnt <= '0;
            else                                         tmo_cnt <= tmo_cnt + 24'd1;
            if (accept) begin
`ifdef UART_DBG_CHECKSUM_EN
                csum_r <= (state == ST_IDLE) ? rx_data : (csum_r ^ rx_data);
`endif
                case (state)
                    ST_IDLE: opcode <= rx_data;
                    // Word-aligned: the two low address bits are dropped as they arrive.
                    ST_GET_ADDR: for (int i = 0; i < AB; i++)
                        if (byte_cnt == 2'(i))
                            mem_addr[8*i +: 8] <= (i == 0) ? {rx_data[7:2], 2'b00} : rx_data;
                    ST_GET_DATA: mem_wdata[{byte_cnt, 3'b000} +: 8] <= rx_data;
                    default: ;
                endcase
            end
            if (bus_go) begin
                mem_we <= (opcode == OP_WRITE);
                mem_re <= (opcode != OP_WRITE);
            end else if (mem_ready) begin
                mem_we <= 1'b0;
                mem_re <= 1'b0;
            end
        end
    end

    rv_uart_dbg_txseq u_txseq (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .reply    (reply),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .done     (tx_done)
    );

endmodule

// File: tb/tb_rv_uart_dbg_bridge.sv
// Directed bench for rv_uart_dbg_bridge with a late-busy UART TX model and a fixed-latency memory model.
module tb_rv_uart_dbg_bridge;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_clr;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy = 1'b0;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ready = 1'b0;
    logic        err;

    int nvec = 0;
    int nmis = 0;

    logic [7:0]  txq[$];
    logic [7:0]  frame_q[$];
    int          viol, we_cyc, re_cyc, err_cyc, unstable, req, mem_lat, dly, bcnt, clr_long;
    logic        prev_clr;
    logic [15:0] last_addr, first_addr;
    logic [31:0] last_wdata, first_wdata, rd_val;

    rv_uart_dbg_bridge #(.ADDR_W(16), .TIMEOUT(24'd100), .VERSION(8'h01)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_clr(rx_clr),
        .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .err(err)
    );

    always #5 clk = ~clk;

    // UART TX model (busy rises two cycles after start, lasts 5) and memory model (ready on the mem_lat-th request cycle).
    initial begin
        dly = 0; bcnt = 0; req = 0; prev_clr = 1'b0; clr_long = 0;
        forever begin
            @(negedge clk);
            if (tx_start) begin
                txq.push_back(tx_data);
                if (tx_busy || dly > 0) viol++;
                dly = 2;
            end else if (dly > 0) begin
                dly--;
                if (dly == 0) begin tx_busy = 1'b1; bcnt = 5; end
            end else if (bcnt > 0) begin
                bcnt--;
                if (bcnt == 0) tx_busy = 1'b0;
            end
            if (mem_we || mem_re) begin
                if (req == 0) begin
                    first_addr = mem_addr; first_wdata = mem_wdata;
                end else if (mem_addr !== first_addr || mem_wdata !== first_wdata) begin
                    unstable++;
                end
                req++;
                if (mem_we) we_cyc++; else re_cyc++;
                last_addr = mem_addr; last_wdata = mem_wdata;
                mem_ready = (req == mem_lat);
                mem_rdata = mem_ready ? rd_val : 32'h0;
            end else begin
                req = 0; mem_ready = 1'b0; mem_rdata = 32'h0;
            end
            if (err) err_cyc++;
            if (rx_clr && prev_clr) clr_long++;
            prev_clr = rx_clr;
        end
    end

    task automatic clear_obs();
        txq.delete();
        viol = 0; we_cyc = 0; re_cyc = 0; err_cyc = 0; unstable = 0;
        last_addr = 16'h0; last_wdata = 32'h0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        rx_data = b; rx_valid = 1'b1;
        while (!rx_clr && n < 100) begin @(negedge clk); n++; end
        if (!rx_clr) begin
            nvec++; nmis++;
            $display("FAIL rx_accept byte %h: rx_clr got 0 after 100 cycles, required 1", b);
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_frame();
        logic [7:0] x;
        x = 8'h00;
        foreach (frame_q[i]) begin
            send_byte(frame_q[i]);
            x = x ^ frame_q[i];
        end
`ifdef UART_DBG_CHECKSUM_EN
        send_byte(x);
`endif
        frame_q.delete();
    endtask

    task automatic wait_tx(input int n, input string name);
        int c;
        c = 0;
        while (txq.size() < n && c < 400) begin @(negedge clk); c++; end
        repeat (30) @(negedge clk);
        nvec++;
        if (txq.size() != n) begin
            nmis++;
            $display("FAIL %s reply count: got %0d bytes, required %0d", name, txq.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        nvec++;
        if ({rx_clr, tx_start, err} !== 3'b000) begin
            nmis++; $display("FAIL reset strobes: got %b, required 000", {rx_clr, tx_start, err});
        end
        nvec++;
        if ({mem_we, mem_re, mem_addr} !== 18'h0) begin
            nmis++; $display("FAIL reset bus ctl: got we=%b re=%b addr=%h, required 0", mem_we, mem_re, mem_addr);
        end
        nvec++;
        if ({tx_data, mem_wdata} !== 40'h0) begin
            nmis++; $display("FAIL reset data: got tx_data=%h wdata=%h, required 0", tx_data, mem_wdata);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_ping();
        clear_obs();
        frame_q = '{8'h50};
        send_frame();
        wait_tx(1, "ping");
        nvec++;
        if (txq[0] !== 8'h01) begin nmis++; $display("FAIL ping reply: got %h, required 01", txq[0]); end
        nvec++;
        if (we_cyc + re_cyc != 0) begin nmis++; $display("FAIL ping bus: got %0d request cycles, required 0", we_cyc + re_cyc); end
    endtask

    task automatic test_write();
        clear_obs();
        mem_lat = 3;
        frame_q = '{8'h57, 8'h10, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        send_frame();
        wait_tx(1, "write");
        nvec++;
        if (we_cyc != 3) begin nmis++; $display("FAIL write we cycles: got %0d, required 3", we_cyc); end
        nvec++;
        if (last_addr !== 16'h0010) begin nmis++; $display("FAIL write addr: got %h, required 0010", last_addr); end
        nvec++;
        if (last_wdata !== 32'hDEADBEEF) begin nmis++; $display("FAIL write wdata: got %h, required deadbeef", last_wdata); end
        nvec++;
        if (unstable != 0 || re_cyc != 0) begin nmis++; $display("FAIL write hold: got unstable=%0d re=%0d, required 0 0", unstable, re_cyc); end
        nvec++;
        if (txq[0] !== 8'h06) begin nmis++; $display("FAIL write ack: got %h, required 06", txq[0]); end
        nvec++;
        if (clr_long != 0) begin nmis++; $display("FAIL rx_clr pulse: got %0d long pulses, required 0", clr_long); end
    endtask

    task automatic test_read(input logic [7:0] a0, input logic [15:0] exp_addr, input logic [31:0] val);
        logic [7:0] expb[4];
        clear_obs();
        mem_lat = 3;
        rd_val = val;
        expb = '{val[7:0], val[15:8], val[23:16], val[31:24]};
        frame_q = '{8'h52, a0, 8'h00};
        send_frame();
        wait_tx(4, "read");
        nvec++;
        if (last_addr !== exp_addr || re_cyc != 3) begin
            nmis++; $display("FAIL read bus: got addr=%h re_cyc=%0d, required %h 3", last_addr, re_cyc, exp_addr);
        end
        for (int i = 0; i < 4; i++) begin
            nvec++;
            if (txq[i] !== expb[i]) begin nmis++; $display("FAIL read byte %0d: got %h, required %h", i, txq[i], expb[i]); end
        end
        nvec++;
        if (viol != 0) begin nmis++; $display("FAIL read pacing: got %0d starts while busy, required 0", viol); end
    endtask

    task automatic test_unknown();
        clear_obs();
        send_byte(8'hAA);
        wait_tx(1, "nak");
        nvec++;
        if (txq[0] !== 8'h15) begin nmis++; $display("FAIL nak reply: got %h, required 15", txq[0]); end
        nvec++;
        if (err_cyc != 1 || we_cyc + re_cyc != 0) begin
            nmis++; $display("FAIL nak err/bus: got err_cyc=%0d bus=%0d, required 1 0", err_cyc, we_cyc + re_cyc);
        end
        test_ping();
    endtask

    task automatic test_timeout();
        int c;
        clear_obs();
        send_byte(8'h57);
        send_byte(8'h10);
        c = 0;
        while (err_cyc == 0 && c < 300) begin @(negedge clk); c++; end
        nvec++;
        if (c < 98 || c > 103) begin nmis++; $display("FAIL timeout delay: got %0d cycles, required 98..103", c); end
        repeat (20) @(negedge clk);
        nvec++;
        if (err_cyc != 1 || we_cyc != 0 || txq.size() != 0) begin
            nmis++; $display("FAIL timeout abort: got err=%0d we=%0d tx=%0d, required 1 0 0", err_cyc, we_cyc, txq.size());
        end
        test_read(8'h20, 16'h0020, 32'hCAFEF00D);
    endtask

    task automatic test_addr_wrap();
        clear_obs();
        mem_lat = 1;
        frame_q = '{8'h57, 8'hFF, 8'hFF, 8'h78, 8'h56, 8'h34, 8'h12};
        send_frame();
        wait_tx(1, "wrap write");
        nvec++;
        if (last_addr !== 16'hFFFC || last_wdata !== 32'h12345678 || we_cyc != 1) begin
            nmis++; $display("FAIL wrap write: got addr=%h wdata=%h we=%0d, required fffc 12345678 1", last_addr, last_wdata, we_cyc);
        end
        nvec++;
        if (txq[0] !== 8'h06) begin nmis++; $display("FAIL wrap ack: got %h, required 06", txq[0]); end
    endtask

    task automatic test_rst_mid();
        int c;
        clear_obs();
        send_byte(8'h57);
        send_byte(8'h10);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        test_ping();
        clear_obs();
        mem_lat = 1000;
        frame_q = '{8'h52, 8'h40, 8'h00};
        send_frame();
        c = 0;
        while (!mem_re && c < 50) begin @(negedge clk); c++; end
        repeat (3) @(negedge clk);
        rst = 1'b1; @(negedge clk);
        nvec++;
        if (mem_re !== 1'b0 || mem_addr !== 16'h0 || re_cyc == 0) begin
            nmis++; $display("FAIL rst mid-bus: got re=%b addr=%h re_cyc=%0d, required 0 0000 >0", mem_re, mem_addr, re_cyc);
        end
        rst = 1'b0;
        clear_obs();
        mem_lat = 2; rd_val = 32'h89ABCDEF;
        frame_q = '{8'h52, 8'h44, 8'h00};
        send_frame();
        c = 0;
        while (txq.size() == 0 && c < 100) begin @(negedge clk); c++; end
        rst = 1'b1; @(negedge clk);
        nvec++;
        if ({tx_start, tx_data, rx_clr, err, mem_we, mem_re, mem_addr, mem_wdata} !== 61'h0) begin
            nmis++; $display("FAIL rst mid-send: got tx_start=%b tx_data=%h we=%b re=%b addr=%h, required all 0", tx_start, tx_data, mem_we, mem_re, mem_addr);
        end
        rst = 1'b0;
        repeat (60) @(negedge clk);
        nvec++;
        if (txq.size() != 1 || txq[0] !== 8'hEF) begin
            nmis++; $display("FAIL rst mid-send tail: got %0d bytes first=%h, required 1 ef", txq.size(), txq[0]);
        end
        test_ping();
    endtask

`ifdef UART_DBG_CHECKSUM_EN
    task automatic test_checksum();
        clear_obs();
        mem_lat = 2; rd_val = 32'hA5A55A5A;
        send_byte(8'h52); send_byte(8'h10); send_byte(8'h00); send_byte(8'h42);
        wait_tx(4, "csum good");
        nvec++;
        if (txq[0] !== 8'h5A || re_cyc != 2 || last_addr !== 16'h0010) begin
            nmis++; $display("FAIL csum good: got b0=%h re=%0d addr=%h, required 5a 2 0010", txq[0], re_cyc, last_addr);
        end
        clear_obs();
        send_byte(8'h52); send_byte(8'h10); send_byte(8'h00); send_byte(8'h00);
        wait_tx(1, "csum bad");
        nvec++;
        if (txq[0] !== 8'h15 || re_cyc != 0 || err_cyc != 1) begin
            nmis++; $display("FAIL csum bad: got tx=%h re=%0d err=%0d, required 15 0 1", txq[0], re_cyc, err_cyc);
        end
    endtask
`endif

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary, required completion");
        $fatal(1);
    end

    initial begin
        mem_lat = 3; rd_val = 32'h0;
        clear_obs();
        test_reset();
        test_ping();
        test_write();
        test_read(8'h13, 16'h0010, 32'h11223344);
        test_unknown();
        test_timeout();
        test_addr_wrap();
        test_rst_mid();
`ifdef UART_DBG_CHECKSUM_EN
        test_checksum();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
